// File: rtl/alu_share_arb.sv
// alu_share_arb: lets several requesters share one ALU instance.
// Requesters are served one at a time in round-robin order over a valid/ready request channel.
// Each operation moves IDLE -> EXEC -> RESP -> IDLE.
// Operands are latched on accept. The ALU result is captured in EXEC and returned in RESP.
module alu_share_arb #(
  parameter int NREQ       = 2,
  parameter int SRCWIDTH   = 32,
  parameter int ALUOPWIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*SRCWIDTH-1:0]   req_src1,
  input  logic [NREQ*SRCWIDTH-1:0]   req_src2,
  input  logic [NREQ*ALUOPWIDTH-1:0] req_aluop,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [SRCWIDTH-1:0]        rsp_result,
  output logic                       rsp_overflow,
  output logic [SRCWIDTH-1:0]        alu_src1,
  output logic [SRCWIDTH-1:0]        alu_src2,
  output logic [ALUOPWIDTH-1:0]      alu_op,
  input  logic [SRCWIDTH-1:0]        alu_result,
  input  logic                       alu_overflow,
  output logic                       busy,
  output logic [31:0]                op_count
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_r;
  logic [IDW-1:0]        rr_ptr_r;
  logic [IDW-1:0]        id_r;
  logic [SRCWIDTH-1:0]   src1_r;
  logic [SRCWIDTH-1:0]   src2_r;
  logic [ALUOPWIDTH-1:0] op_r;
  logic [SRCWIDTH-1:0]   result_r;
  logic                  ovf_r;
  logic [NREQ-1:0]       rsp_valid_r;
  logic                  busy_r;
  logic [31:0]           op_count_r;

  logic [IDW-1:0]        grant_s;
  logic                  found_s;
  logic                  accept_s;
  logic                  handshake_s;

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
    logic [NREQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Round-robin search: the first valid requester at or after rr_ptr wins.
  always_comb begin
    logic [IDW-1:0] idx;
    found_s = 1'b0;
    grant_s = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr_r) + k) % NREQ);
      if (!found_s && req_valid[idx]) begin
        found_s = 1'b1;
        grant_s = idx;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Ready goes to the granted requester only. It is combinational on valid, and only while idle.
  always_comb begin
    req_ready = '0;
    if ((state_r == IDLE) && found_s) begin
      req_ready = onehot(grant_s);
    end else begin
      req_ready = '0;
    end
  end

  assign accept_s    = (state_r == IDLE) && found_s;
  assign handshake_s = (state_r == RESP) && rsp_ready[id_r];

  // Sequencing FSM. It holds the operand, result, pointer and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      id_r        <= '0;
      src1_r      <= '0;
      src2_r      <= '0;
      op_r        <= '0;
      result_r    <= '0;
      ovf_r       <= 1'b0;
      rsp_valid_r <= '0;
      busy_r      <= 1'b0;
      op_count_r  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            src1_r  <= req_src1[int'(grant_s)*SRCWIDTH +: SRCWIDTH];
            src2_r  <= req_src2[int'(grant_s)*SRCWIDTH +: SRCWIDTH];
            op_r    <= req_aluop[int'(grant_s)*ALUOPWIDTH +: ALUOPWIDTH];
            id_r    <= grant_s;
            busy_r  <= 1'b1;
            state_r <= EXEC;
          end
        end
        EXEC: begin
          result_r    <= alu_result;
          ovf_r       <= alu_overflow;
          rsp_valid_r <= onehot(id_r);
          state_r     <= RESP;
        end
        RESP: begin
          if (handshake_s) begin
            rsp_valid_r <= '0;
            busy_r      <= 1'b0;
            op_count_r  <= op_count_r + 32'd1;
            // Priority moves past the requester that just completed.
            if (int'(id_r) == NREQ - 1) begin
              rr_ptr_r <= '0;
            end else begin
              rr_ptr_r <= id_r + IDW'(1);
            end
            state_r <= IDLE;
          end
        end
        default: begin
          rsp_valid_r <= '0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_r;
  assign rsp_result   = result_r;
  assign rsp_overflow = ovf_r;
  assign alu_src1     = src1_r;
  assign alu_src2     = src2_r;
  assign alu_op       = op_r;
  assign busy         = busy_r;
  assign op_count     = op_count_r;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed testbench for alu_share_arb.
// A small behavioural ALU closes the loop on the alu_* ports.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_src1;
  logic [63:0] req_src2;
  logic [7:0]  req_aluop;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_overflow;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        busy;
  logic [31:0] op_count;

  int checks = 0;
  int errors = 0;

  alu_share_arb #(.NREQ(2), .SRCWIDTH(32), .ALUOPWIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_aluop(req_aluop),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference ALU opcodes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  always_comb begin
    alu_result   = 32'd0;
    alu_overflow = 1'b0;
    case (alu_op)
      4'd0: begin
        alu_result   = alu_src1 + alu_src2;
        alu_overflow = (alu_src1[31] == alu_src2[31]) && (alu_result[31] != alu_src1[31]);
      end
      4'd1: begin
        alu_result   = alu_src1 - alu_src2;
        alu_overflow = (alu_src1[31] != alu_src2[31]) && (alu_result[31] != alu_src1[31]);
      end
      4'd2: alu_result = alu_src1 << alu_src2[4:0];
      4'd3: alu_result = {31'd0, ($signed(alu_src1) < $signed(alu_src2))};
      4'd4: alu_result = {31'd0, (alu_src1 < alu_src2)};
      4'd5: alu_result = alu_src1 ^ alu_src2;
      4'd6: alu_result = alu_src1 >> alu_src2[4:0];
      4'd7: alu_result = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);
      4'd8: alu_result = alu_src1 | alu_src2;
      4'd9: alu_result = alu_src1 & alu_src2;
      default: alu_result = 32'd0;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req_src1[i*32 +: 32] = a;
    req_src2[i*32 +: 32] = b;
    req_aluop[i*4 +: 4]  = op;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
    checks++; if (rsp_result !== 32'd0 || rsp_overflow !== 1'b0) begin errors++; $display("FAIL rst_rsp: got %h/%b want 0/0", rsp_result, rsp_overflow); end
    checks++; if (alu_src1 !== 32'd0 || alu_src2 !== 32'd0 || alu_op !== 4'd0) begin errors++; $display("FAIL rst_alu: got %h %h %h want 0", alu_src1, alu_src2, alu_op); end
    checks++; if (op_count !== 32'd0) begin errors++; $display("FAIL rst_op_count: got %h want 0", op_count); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready_idle: got %b want 00", req_ready); end
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_ready_valid: got %b want 01", req_ready); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_blocks_accept: got busy %b want 0", busy); end
    req_valid = 2'b00;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    set_req(0, 32'h7FFFFFFF, 32'h00000001, 4'd0);
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++; if (busy !== 1'b1 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin errors++; $display("FAIL single_exec: got busy %b rdy %b rv %b want 1 00 00", busy, req_ready, rsp_valid); end
    checks++; if (alu_src1 !== 32'h7FFFFFFF || alu_src2 !== 32'h1 || alu_op !== 4'd0) begin errors++; $display("FAIL single_alu_drive: got %h %h %h", alu_src1, alu_src2, alu_op); end
    tick();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); end
    checks++; if (rsp_result !== 32'h80000000 || rsp_overflow !== 1'b1) begin errors++; $display("FAIL single_result: got %h/%b want 80000000/1", rsp_result, rsp_overflow); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || op_count !== 32'd1) begin errors++; $display("FAIL single_done: got rv %b busy %b cnt %h want 00 0 1", rsp_valid, busy, op_count); end
  endtask

  task automatic test_round_robin;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 32'd5, 32'd7, 4'd1);
    set_req(1, 32'h80000000, 32'd4, 4'd7);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_first_grant: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b10;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rr_exec_ready: got %b want 00", req_ready); end
    tick();
    checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'hFFFFFFFE || rsp_overflow !== 1'b0) begin errors++; $display("FAIL rr_sub: got %b %h %b want 01 fffffffe 0", rsp_valid, rsp_result, rsp_overflow); end
    tick();
    set_req(0, 32'd3, 32'd4, 4'd0);
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_second_grant: got %b want 10", req_ready); end
    tick();
    req_valid = 2'b01;
    tick();
    checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'hF8000000 || rsp_overflow !== 1'b0) begin errors++; $display("FAIL rr_sra: got %b %h %b want 10 f8000000 0", rsp_valid, rsp_result, rsp_overflow); end
    tick();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_third_grant: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd7) begin errors++; $display("FAIL rr_third_result: got %b %h want 01 7", rsp_valid, rsp_result); end
    tick();
    rsp_ready = 2'b00;
    checks++; if (op_count !== 32'd3) begin errors++; $display("FAIL rr_count: got %h want 3", op_count); end
  endtask

  task automatic test_backpressure;
    set_req(1, 32'd10, 32'd20, 4'd0);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    tick();
    req_valid = 2'b01;
    tick();
    rsp_ready = 2'b01;
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'd30 || req_ready !== 2'b00 || op_count !== 32'd3) begin
        errors++; $display("FAIL bp_hold cycle %0d: got rv %b res %h rdy %b cnt %h want 10 1e 00 3", c, rsp_valid, rsp_result, req_ready, op_count);
      end
      tick();
    end
    rsp_ready = 2'b10;
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00 || op_count !== 32'd4 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got rv %b cnt %h busy %b want 00 4 0", rsp_valid, op_count, busy); end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1, 32'd1, 32'd2, 4'd0);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_exec_busy: got %b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || op_count !== 32'd0) begin errors++; $display("FAIL rm_exec: got busy %b rv %b cnt %h want 0 00 0", busy, rsp_valid, op_count); end
    tick();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_exec_no_rsp: got %b want 00", rsp_valid); end
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rm_resp_pre: got %b want 10", rsp_valid); end
    rst = 1'b1;
    rsp_ready = 2'b10;
    tick();
    rst = 1'b0;
    rsp_ready = 2'b00;
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || op_count !== 32'd0) begin errors++; $display("FAIL rm_resp: got busy %b rv %b cnt %h want 0 00 0", busy, rsp_valid, op_count); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_rr_ptr: got %b want 01", req_ready); end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_ops;
    logic [31:0] a_t [4]    = '{32'd5, 32'd1, 32'd1, 32'h80000000};
    logic [31:0] b_t [4]    = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1};
    logic [3:0]  op_t [4]   = '{4'd12, 4'd4, 4'd3, 4'd1};
    logic [31:0] res_t [4]  = '{32'd0, 32'd1, 32'd0, 32'h7FFFFFFF};
    logic        ovf_t [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int v = 0; v < 4; v++) begin
      set_req(0, a_t[v], b_t[v], op_t[v]);
      req_valid = 2'b01;
      rsp_ready = 2'b01;
      tick();
      req_valid = 2'b00;
      checks++; if (alu_op !== op_t[v]) begin errors++; $display("FAIL ops_alu_op %0d: got %h want %h", v, alu_op, op_t[v]); end
      tick();
      checks++; if (rsp_valid !== 2'b01 || rsp_result !== res_t[v] || rsp_overflow !== ovf_t[v]) begin
        errors++; $display("FAIL ops_result %0d: got %b %h %b want 01 %h %b", v, rsp_valid, rsp_result, rsp_overflow, res_t[v], ovf_t[v]);
      end
      tick();
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_wrap;
    force dut.op_count_r = 32'hFFFFFFFF;
    tick();
    release dut.op_count_r;
    checks++; if (op_count !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffffffff", op_count); end
    set_req(1, 32'd2, 32'd2, 4'd9);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (rsp_result !== 32'd2) begin errors++; $display("FAIL wrap_result: got %h want 2", rsp_result); end
    tick();
    rsp_ready = 2'b00;
    checks++; if (op_count !== 32'd0) begin errors++; $display("FAIL wrap_count: got %h want 0", op_count); end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_src1  = 64'd0;
    req_src2  = 64'd0;
    req_aluop = 8'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_ops();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
